module_20_sdf_bfly: RTL and testbench

- First radix-2 butterfly of stage 2. Consumes the CBFP-normalised stream from module_1: 16 lanes per clock, 32 beats per 512-point frame.
- Pairs each even beat with the following odd beat in the same lane, which is a distance-16 butterfly.
- Emits the sum and difference on consecutive cycles, so throughput is continuous.
- Carries the per-lane CBFP index alongside the data for later exponent compensation.

---
 rtl/module_20_sdf_bfly.sv | 125 ++++++++++++
 tb/tb_module_20_sdf_bfly.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/module_20_sdf_bfly.sv
// rtl/module_20_sdf_bfly.sv - stage-2 first radix-2 butterfly, distance-16 pairs, sum then diff per pair
module module_20_sdf_bfly #(
  parameter int WIDTH       = 12,
  parameter int NLANE       = 16,
  parameter int FRAME_BEATS = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic signed [WIDTH-1:0] module_1_out_re [0:NLANE-1],
  input  logic signed [WIDTH-1:0] module_1_out_im [0:NLANE-1],
  input  logic        [4:0]       idx1            [0:NLANE-1],
  input  logic                    module2_valid,
  output logic signed [WIDTH:0]   bfly20_re       [0:NLANE-1],
  output logic signed [WIDTH:0]   bfly20_im       [0:NLANE-1],
  output logic        [4:0]       idx20           [0:NLANE-1],
  output logic                    bfly20_valid,
  output logic                    frame_start
);

  localparam int            CW        = $clog2(FRAME_BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);
  localparam logic [CW-1:0] SUM_BEAT  = CW'(1);

  logic        [CW-1:0]  r_beat_cnt;
  logic signed [WIDTH-1:0] r_hold_re  [0:NLANE-1];
  logic signed [WIDTH-1:0] r_hold_im  [0:NLANE-1];
  logic        [4:0]       r_hold_idx [0:NLANE-1];
  logic signed [WIDTH:0]   r_diff_re  [0:NLANE-1];
  logic signed [WIDTH:0]   r_diff_im  [0:NLANE-1];
  logic        [4:0]       r_dif_idx  [0:NLANE-1];
  logic                    r_diff_pend;
  logic signed [WIDTH:0]   r_out_re   [0:NLANE-1];
  logic signed [WIDTH:0]   r_out_im   [0:NLANE-1];
  logic        [4:0]       r_out_idx  [0:NLANE-1];
  logic                    r_out_valid;
  logic                    r_frame_start;

  logic signed [WIDTH:0]   w_sum_re   [0:NLANE-1];
  logic signed [WIDTH:0]   w_sum_im   [0:NLANE-1];
  logic signed [WIDTH:0]   w_dif_re   [0:NLANE-1];
  logic signed [WIDTH:0]   w_dif_im   [0:NLANE-1];
  logic                    w_even;
  logic                    w_odd;

  assign w_even = module2_valid & ~r_beat_cnt[0];
  assign w_odd  = module2_valid &  r_beat_cnt[0];

  // Per-lane sign-extended add/subtract of the held even beat against the incoming odd beat
  always_comb begin
    for (int i = 0; i < NLANE; i++) begin
      w_sum_re[i] = {r_hold_re[i][WIDTH-1], r_hold_re[i]} + {module_1_out_re[i][WIDTH-1], module_1_out_re[i]};
      w_sum_im[i] = {r_hold_im[i][WIDTH-1], r_hold_im[i]} + {module_1_out_im[i][WIDTH-1], module_1_out_im[i]};
      w_dif_re[i] = {r_hold_re[i][WIDTH-1], r_hold_re[i]} - {module_1_out_re[i][WIDTH-1], module_1_out_re[i]};
      w_dif_im[i] = {r_hold_im[i][WIDTH-1], r_hold_im[i]} - {module_1_out_im[i][WIDTH-1], module_1_out_im[i]};
    end
  end

  // Beat counter, even-beat hold, sum output on the odd beat and the deferred diff one cycle later
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_beat_cnt    <= '0;
      r_diff_pend   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < NLANE; i++) begin
        r_hold_re[i]  <= '0;
        r_hold_im[i]  <= '0;
        r_hold_idx[i] <= '0;
        r_diff_re[i]  <= '0;
        r_diff_im[i]  <= '0;
        r_dif_idx[i]  <= '0;
        r_out_re[i]   <= '0;
        r_out_im[i]   <= '0;
        r_out_idx[i]  <= '0;
      end
    end else begin
      r_out_valid   <= 1'b0;
      r_frame_start <= 1'b0;

      if (module2_valid) begin
        r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
      end

      // The diff slot can never coincide with an odd beat: an odd beat is always preceded by an even one.
      if (r_diff_pend) begin
        r_out_valid <= 1'b1;
        r_diff_pend <= 1'b0;
        for (int i = 0; i < NLANE; i++) begin
          r_out_re[i]  <= r_diff_re[i];
          r_out_im[i]  <= r_diff_im[i];
          r_out_idx[i] <= r_dif_idx[i];
        end
      end

      if (w_even) begin
        for (int i = 0; i < NLANE; i++) begin
          r_hold_re[i]  <= module_1_out_re[i];
          r_hold_im[i]  <= module_1_out_im[i];
          r_hold_idx[i] <= idx1[i];
        end
      end

      if (w_odd) begin
        r_out_valid   <= 1'b1;
        r_diff_pend   <= 1'b1;
        r_frame_start <= (r_beat_cnt == SUM_BEAT);
        for (int i = 0; i < NLANE; i++) begin
          r_out_re[i]  <= w_sum_re[i];
          r_out_im[i]  <= w_sum_im[i];
          r_out_idx[i] <= r_hold_idx[i];
          r_diff_re[i] <= w_dif_re[i];
          r_diff_im[i] <= w_dif_im[i];
          r_dif_idx[i] <= idx1[i];
        end
      end
    end
  end

  assign bfly20_re    = r_out_re;
  assign bfly20_im    = r_out_im;
  assign idx20        = r_out_idx;
  assign bfly20_valid = r_out_valid;
  assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_module_20_sdf_bfly.sv
// tb/tb_module_20_sdf_bfly.sv - self-checking bench for module_20_sdf_bfly
module tb_module_20_sdf_bfly;

  localparam int W = 12;
  localparam int N = 16;

  logic                clk = 1'b0;
  logic                rstn;
  logic signed [W-1:0] in_re  [0:N-1];
  logic signed [W-1:0] in_im  [0:N-1];
  logic        [4:0]   in_idx [0:N-1];
  logic                vld;
  logic signed [W:0]   o_re   [0:N-1];
  logic signed [W:0]   o_im   [0:N-1];
  logic        [4:0]   o_idx  [0:N-1];
  logic                o_vld;
  logic                o_fs;

  module_20_sdf_bfly #(.WIDTH(W), .NLANE(N), .FRAME_BEATS(32)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .module_1_out_re (in_re),
    .module_1_out_im (in_im),
    .idx1            (in_idx),
    .module2_valid   (vld),
    .bfly20_re       (o_re),
    .bfly20_im       (o_im),
    .idx20           (o_idx),
    .bfly20_valid    (o_vld),
    .frame_start     (o_fs)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: frame beat number, last even beat, and a time-stamped queue of expected output beats
  int m_beat;
  int ev_re [N];
  int ev_im [N];
  int ev_idx[N];
  int q_cyc [$];
  int q_fs  [$];
  int q_re  [$];
  int q_im  [$];
  int q_idx [$];
  int last_re [N];
  int last_im [N];
  int last_idx[N];

  task automatic model_reset();
    m_beat = 0;
    q_cyc.delete(); q_fs.delete(); q_re.delete(); q_im.delete(); q_idx.delete();
    for (int i = 0; i < N; i++) begin
      ev_re[i] = 0; ev_im[i] = 0; ev_idx[i] = 0;
      last_re[i] = 0; last_im[i] = 0; last_idx[i] = 0;
    end
  endtask

  task automatic model_input(input int c);
    int a_re, a_im;
    if (m_beat % 2 == 0) begin
      for (int i = 0; i < N; i++) begin
        ev_re[i] = in_re[i]; ev_im[i] = in_im[i]; ev_idx[i] = in_idx[i];
      end
    end else begin
      q_cyc.push_back(c);     q_fs.push_back(m_beat == 1 ? 1 : 0);
      for (int i = 0; i < N; i++) begin
        a_re = in_re[i]; a_im = in_im[i];
        q_re.push_back(ev_re[i] + a_re); q_im.push_back(ev_im[i] + a_im); q_idx.push_back(ev_idx[i]);
      end
      q_cyc.push_back(c + 1); q_fs.push_back(0);
      for (int i = 0; i < N; i++) begin
        a_re = in_re[i]; a_im = in_im[i];
        q_re.push_back(ev_re[i] - a_re); q_im.push_back(ev_im[i] - a_im); q_idx.push_back(int'(in_idx[i]));
      end
    end
    m_beat = (m_beat + 1) % 32;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Compare all outputs against the model expectation for cycle c
  task automatic check(input int c);
    logic             e_v, e_fs;
    logic signed [W:0] e_re, e_im;
    logic [4:0]        e_idx;
    int tmp;
    e_v = 1'b0; e_fs = 1'b0;
    if (q_cyc.size() > 0 && q_cyc[0] == c) begin
      tmp = q_cyc.pop_front();
      e_v = 1'b1;
      e_fs = (q_fs.pop_front() != 0);
      for (int i = 0; i < N; i++) begin
        last_re[i] = q_re.pop_front(); last_im[i] = q_im.pop_front(); last_idx[i] = q_idx.pop_front();
      end
    end
    n_vec++;
    assert (o_vld === e_v) else begin
      n_err++; $error("FAIL valid c=%0d: observed %b expected %b", c, o_vld, e_v);
    end
    n_vec++;
    assert (o_fs === e_fs) else begin
      n_err++; $error("FAIL frame_start c=%0d: observed %b expected %b", c, o_fs, e_fs);
    end
    for (int i = 0; i < N; i++) begin
      e_re = last_re[i][W:0]; e_im = last_im[i][W:0]; e_idx = last_idx[i][4:0];
      n_vec++;
      assert (o_re[i] === e_re && o_im[i] === e_im && o_idx[i] === e_idx) else begin
        n_err++;
        $error("FAIL lane%0d c=%0d: observed re=%0d im=%0d idx=%0d expected re=%0d im=%0d idx=%0d",
               i, c, o_re[i], o_im[i], o_idx[i], e_re, e_im, e_idx);
      end
    end
  endtask

  task automatic step(input logic v);
    vld = v;
    @(posedge clk);
    cyc++;
    if (v && !rstn) model_input(cyc);
    #1;
    check(cyc);
  endtask

  task automatic rand_in();
    for (int i = 0; i < N; i++) begin
      in_re[i] = W'($urandom); in_im[i] = W'($urandom); in_idx[i] = 5'($urandom);
    end
  endtask

  task automatic set_all(input int re, input int im);
    for (int i = 0; i < N; i++) begin
      in_re[i] = W'(re); in_im[i] = W'(im);
    end
  endtask

  task automatic do_reset();
    vld  = 1'b0;
    rstn = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    check(cyc);
    rstn = 1'b0;
  endtask

  int fs_cnt;

  initial begin
    vld = 1'b0;
    rstn = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_re[i] = '0; in_im[i] = '0; in_idx[i] = '0;
    end

    // Reset state
    do_reset();
    chk("reset_valid", int'(o_vld), 0);

    // Single pair on lane 0
    rand_in();
    in_re[0] = 100; in_im[0] = -50;
    step(1);
    chk("pair_even_noout", int'(o_vld), 0);
    rand_in();
    in_re[0] = 30; in_im[0] = 20;
    step(1);
    chk("pair_sum_re", int'(o_re[0]), 130);
    chk("pair_sum_im", int'(o_im[0]), -30);
    chk("pair_sum_fs", int'(o_fs), 1);
    step(0);
    chk("pair_dif_re", int'(o_re[0]), 70);
    chk("pair_dif_im", int'(o_im[0]), -70);
    chk("pair_dif_fs", int'(o_fs), 0);
    step(0);

    // Extremes on all lanes
    set_all(2047, 2047);   step(1);
    set_all(2047, 2047);   step(1);
    chk("ext_sum_max", int'(o_re[9]), 4094);
    set_all(-2048, -2048); step(1);
    chk("ext_dif_zero", int'(o_re[9]), 0);
    set_all(2047, 2047);   step(1);
    chk("ext_sum_neg1", int'(o_re[15]), -1);
    step(0);
    chk("ext_dif_min", int'(o_im[15]), -4095);
    step(0);

    // Two full frames back-to-back, lane value = beat number
    do_reset();
    fs_cnt = 0;
    for (int b = 0; b < 64; b++) begin
      set_all(b % 32, -(b % 32));
      for (int i = 0; i < N; i++) in_idx[i] = 5'($urandom);
      step(1);
      fs_cnt += int'(o_fs);
      if (b % 2 == 1) chk("ff_sum", int'(o_re[7]), 4 * ((b % 32) / 2) + 1);
      else if (b > 0) chk("ff_dif", int'(o_re[7]), -1);
    end
    step(0);
    chk("ff_dif_last", int'(o_re[7]), -1);
    chk("ff_fs_count", fs_cnt, 2);
    step(0);

    // Bubbles: beat0, 3 idle, beat1, 2 idle, beat2, beat3
    rand_in(); step(1);
    repeat (3) step(0);
    rand_in(); step(1);
    chk("bub_sum_valid", int'(o_vld), 1);
    step(0);
    chk("bub_dif_valid", int'(o_vld), 1);
    step(0);
    rand_in(); step(1);
    rand_in(); step(1);
    step(0);
    step(0);

    // idx alignment on lanes 0 and 15
    rand_in(); in_idx[0] = 3; in_idx[15] = 11; step(1);
    rand_in(); in_idx[0] = 7; in_idx[15] = 20; step(1);
    chk("idx_sum_l0", int'(o_idx[0]), 3);
    chk("idx_sum_l15", int'(o_idx[15]), 11);
    step(0);
    chk("idx_dif_l0", int'(o_idx[0]), 7);
    chk("idx_dif_l15", int'(o_idx[15]), 20);
    step(0);

    // Reset asserted while an odd beat is presented
    rand_in(); step(1);
    rand_in(); step(1);
    rand_in(); step(1);
    rand_in(); vld = 1'b1;
    #2;
    rstn = 1'b1;
    model_reset();
    #1;
    check(cyc);
    chk("rst_async_valid", int'(o_vld), 0);
    @(posedge clk);
    cyc++;
    #1;
    check(cyc);
    rstn = 1'b0;
    rand_in(); step(1);
    chk("rst_even_noout", int'(o_vld), 0);
    rand_in(); step(1);
    chk("rst_then_sum", int'(o_vld), 1);
    chk("rst_then_fs", int'(o_fs), 1);
    step(0);

    // Random traffic with random bubbles
    for (int k = 0; k < 300; k++) begin
      rand_in();
      step(logic'($urandom_range(0, 3) != 0));
    end
    repeat (3) step(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
